// File: rtl/mel_log_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mel_log_sequencer_if                                            |
// | Brief    : Energy-in / log-out stream bundle for mel_log_sequencer.        |
// |            slave = sequencer side, master = producer/consumer side.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface mel_log_sequencer_if #(
  parameter int IDX_W = 5
) ();
  logic [31:0]      energy_i;
  logic             energy_valid_i;
  logic             energy_ready_o;
  logic [7:0]       log_o;
  logic [IDX_W-1:0] log_idx_o;
  logic             log_last_o;
  logic             log_valid_o;
  logic             log_ready_i;
  logic [15:0]      frame_cnt_o;

  modport slave (
    input  energy_i, energy_valid_i, log_ready_i,
    output energy_ready_o, log_o, log_idx_o, log_last_o, log_valid_o, frame_cnt_o
  );

  modport master (
    output energy_i, energy_valid_i, log_ready_i,
    input  energy_ready_o, log_o, log_idx_o, log_last_o, log_valid_o, frame_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/mel_log_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mel_log_sequencer                                               |
// | Brief    : Buffers one frame of N_BANDS mel energies, then streams         |
// |            6*log2 approximations out in band order with index, last flag  |
// |            and a completed-frame counter.                                  |
// | Options  : define MEL_LOG_FRAC_EN to add the +3 half-octave fraction term. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mel_log_sequencer #(
  parameter int N_BANDS = 26,
  parameter int IDX_W   = 5
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  mel_log_sequencer_if.slave  bus
);

  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] C_WR_LAST = IDX_W'(N_BANDS - 1);
  localparam logic [IDX_W:0]   C_RD_END  = (IDX_W + 1)'(N_BANDS);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d;
  // One extra bit so the read counter can sit past the last band (N_BANDS may be 2^IDX_W).
  logic [IDX_W:0]   rd_cnt_q, rd_cnt_d;
  logic [7:0]       log_q, log_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic [15:0]      frame_q, frame_d;
  logic [31:0]      mem_q [N_BANDS];

  logic             w_ready;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_we;
  logic [IDX_W-1:0] w_rd_idx;
  logic [31:0]      w_x;
  logic [4:0]       w_msb;
  logic [7:0]       w_log;

  // Input is only accepted while filling and never while reset is held.
  assign w_ready    = (state_q == S_FILL) && rst_n;
  assign w_in_xfer  = w_ready && bus.energy_valid_i;
  assign w_out_xfer = valid_q && bus.log_ready_i;

  // Clamp the read address once the counter has run past the last band.
  always_comb begin
    w_rd_idx = '0;
    if (rd_cnt_q < C_RD_END) begin
      w_rd_idx = rd_cnt_q[IDX_W-1:0];
    end
  end

  assign w_x = mem_q[w_rd_idx];

`ifdef MEL_LOG_FRAC_EN
  logic w_frac;

  // Priority encoder: msb position plus the bit just below it as half-octave hint.
  always_comb begin
    w_msb  = '0;
    w_frac = 1'b0;
    for (int i = 1; i < 32; i++) begin
      if (w_x[i]) begin
        w_msb  = 5'(i);
        w_frac = w_x[i-1];
      end
    end
  end

  // 6*p peaks at 186, +3 at 189, so 8 bits never overflow.
  assign w_log = ({3'b000, w_msb} * 8'd6) + (w_frac ? 8'd3 : 8'd0);
`else
  // Priority encoder: msb position; 0 and 1 both map to position 0.
  always_comb begin
    w_msb = '0;
    for (int i = 1; i < 32; i++) begin
      if (w_x[i]) begin
        w_msb = 5'(i);
      end
    end
  end

  assign w_log = {3'b000, w_msb} * 8'd6;
`endif

  // Next-state logic: fill counter, drain output register and frame counter.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    log_d    = log_q;
    idx_d    = idx_q;
    last_d   = last_q;
    valid_d  = valid_q;
    frame_d  = frame_q;
    w_we     = 1'b0;

    case (state_q)
      S_FILL: begin
        if (w_in_xfer) begin
          w_we = 1'b1;
          if (wr_cnt_q == C_WR_LAST) begin
            wr_cnt_d = '0;
            state_d  = S_DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end

      S_DRAIN: begin
        if (w_out_xfer) begin
          valid_d = 1'b0;
        end
        if (w_out_xfer && last_q) begin
          rd_cnt_d = '0;
          frame_d  = frame_q + 16'd1;
          state_d  = S_FILL;
        end else if ((!valid_q || w_out_xfer) && (rd_cnt_q < C_RD_END)) begin
          log_d    = w_log;
          idx_d    = rd_cnt_q[IDX_W-1:0];
          last_d   = (rd_cnt_q == C_RD_END - 1'b1);
          valid_d  = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // State and control registers; synchronous active-low reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FILL;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      log_q    <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      log_q    <= log_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      frame_q  <= frame_d;
    end
  end

  // Frame buffer; contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (w_we) begin
      mem_q[wr_cnt_q] <= bus.energy_i;
    end
  end

  assign bus.energy_ready_o = w_ready;
  assign bus.log_o          = log_q;
  assign bus.log_idx_o      = idx_q;
  assign bus.log_last_o     = last_q;
  assign bus.log_valid_o    = valid_q;
  assign bus.frame_cnt_o    = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_mel_log_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mel_log_sequencer                                            |
// | Brief    : Table-driven self-checking bench for mel_log_sequencer.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mel_log_sequencer;

  localparam int N     = 26;
  localparam int IDX_W = 5;

  typedef struct {
    logic [31:0] energy;
    logic [7:0]  exp_log;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  logic [15:0] exp_frame;
  vec_t tbl_a [N];
  vec_t tbl_b [N];
  vec_t cur   [N];

  mel_log_sequencer_if #(.IDX_W(IDX_W)) bus ();

  mel_log_sequencer #(.N_BANDS(N), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Push cur[] into the sequencer; returns the cycle of the last accepted word.
  task automatic send_frame(input bit gaps, output int t_last);
    int guard;
    t_last = 0;
    for (int i = 0; i < N; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        bus.energy_valid_i = 1'b0;
        bus.energy_i       = $urandom;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      bus.energy_i       = cur[i].energy;
      bus.energy_valid_i = 1'b1;
      guard = 0;
      while (bus.energy_ready_o !== 1'b1 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        chk("fill_timeout", 32'd0, 32'd1);
        bus.energy_valid_i = 1'b0;
        return;
      end
      t_last = cyc;
      @(negedge clk);
    end
    bus.energy_valid_i = 1'b0;
    bus.energy_i       = 32'hDEAD_BEEF;
  endtask

  // Drain up to stop_after beats, checking data, order, hold under stall and timing.
  task automatic collect(input bit rnd, input int stop_after, input int t_last);
    int   k;
    int   guard;
    int   first_cyc;
    int   last_cyc;
    bit   stalled;
    bit   ready_err;
    bit   r;
    logic [7:0]       p_log;
    logic [IDX_W-1:0] p_idx;
    logic             p_last;
    k = 0; guard = 0; first_cyc = -1; last_cyc = -1;
    stalled = 1'b0; ready_err = 1'b0;
    p_log = '0; p_idx = '0; p_last = 1'b0;
    while (k < stop_after && guard < 2000) begin
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.log_ready_i = r;
      if (stalled) begin
        chk("hold_valid", 32'(bus.log_valid_o), 32'd1);
        chk("hold_beat", {bus.log_o, 3'b000, bus.log_idx_o, 7'd0, bus.log_last_o},
                         {p_log, 3'b000, p_idx, 7'd0, p_last});
      end
      if (bus.energy_ready_o !== 1'b0) ready_err = 1'b1;
      if (bus.log_valid_o === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (r) begin
          chk($sformatf("log[%0d]", k), 32'(bus.log_o), 32'(cur[k].exp_log));
          chk($sformatf("idx[%0d]", k), 32'(bus.log_idx_o), 32'(k));
          chk($sformatf("last[%0d]", k), 32'(bus.log_last_o), 32'(k == N - 1));
          if (k == N - 1) last_cyc = cyc;
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          p_log   = bus.log_o;
          p_idx   = bus.log_idx_o;
          p_last  = bus.log_last_o;
        end
      end
      @(negedge clk);
      guard++;
    end
    bus.log_ready_i = 1'b1;
    if (guard >= 2000) chk("drain_timeout", 32'd0, 32'd1);
    chk("ready_low_in_drain", 32'(ready_err), 32'd0);
    chk("first_beat_cycle", 32'(first_cyc), 32'(t_last + 2));
    if (!rnd && stop_after == N) chk("last_beat_cycle", 32'(last_cyc), 32'(t_last + N + 1));
  endtask

  task automatic frame_end();
    exp_frame = exp_frame + 16'd1;
    chk("frame_cnt", 32'(bus.frame_cnt_o), 32'(exp_frame));
    chk("ready_after_frame", 32'(bus.energy_ready_o), 32'd1);
    chk("valid_after_frame", 32'(bus.log_valid_o), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(bus.energy_ready_o), 32'd0);
    chk({tag, "_log"},   32'(bus.log_o),          32'd0);
    chk({tag, "_idx"},   32'(bus.log_idx_o),      32'd0);
    chk({tag, "_last"},  32'(bus.log_last_o),     32'd0);
    chk({tag, "_valid"}, 32'(bus.log_valid_o),    32'd0);
    chk({tag, "_frame"}, 32'(bus.frame_cnt_o),    32'd0);
  endtask

  task automatic load_b(input int i, input logic [31:0] x, input logic [7:0] e_int,
                        input logic [7:0] e_frac);
    tbl_b[i].energy = x;
`ifdef MEL_LOG_FRAC_EN
    tbl_b[i].exp_log = e_frac;
`else
    tbl_b[i].exp_log = e_int;
`endif
  endtask

  initial begin
    int t_last;
    total = 0; bad = 0; cyc = 0; exp_frame = '0;
    rst_n = 1'b0;
    bus.energy_i = '0; bus.energy_valid_i = 1'b0; bus.log_ready_i = 1'b1;

    // Table A: powers of two, 6*k expected in both builds.
    for (int k = 0; k < N; k++) begin
      tbl_a[k].energy  = 32'd1 << k;
      tbl_a[k].exp_log = 8'(6 * k);
    end
    // Table B: edge values (integer result, fractional result).
    load_b( 0, 32'h0000_0000,   0,   0);
    load_b( 1, 32'h0000_0001,   0,   0);
    load_b( 2, 32'h8000_0000, 186, 186);
    load_b( 3, 32'hFFFF_FFFF, 186, 189);
    load_b( 4, 32'h0000_0003,   6,   9);
    load_b( 5, 32'h0000_0002,   6,   6);
    load_b( 6, 32'h0000_0005,  12,  12);
    load_b( 7, 32'h0000_0006,  12,  15);
    load_b( 8, 32'h0000_0007,  12,  15);
    load_b( 9, 32'h0000_000C,  18,  21);
    load_b(10, 32'h4000_0000, 180, 180);
    load_b(11, 32'hC000_0000, 186, 189);
    load_b(12, 32'h7FFF_FFFF, 180, 183);
    load_b(13, 32'd100,        36,  39);
    load_b(14, 32'd255,        42,  45);
    load_b(15, 32'd256,        48,  48);
    load_b(16, 32'h0001_0000,  96,  96);
    load_b(17, 32'h0001_8000,  96,  99);
    load_b(18, 32'h0001_4000,  96,  96);
    load_b(19, 32'h0000_0004,  12,  12);
    load_b(20, 32'h0F00_0000, 162, 165);
    load_b(21, 32'h0900_0000, 162, 162);
    load_b(22, 32'h0000_0010,  24,  24);
    load_b(23, 32'h0000_0030,  30,  33);
    load_b(24, 32'h0000_0020,  30,  30);
    load_b(25, 32'h0000_0002,   6,   6);

    // Reset state, then ready one cycle after release.
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(bus.energy_ready_o), 32'd1);

    // Basic frame, no gaps, no backpressure.
    cur = tbl_a;
    send_frame(1'b0, t_last);
    collect(1'b0, N, t_last);
    frame_end();

    // Edge values with input throttling.
    cur = tbl_b;
    send_frame(1'b1, t_last);
    collect(1'b0, N, t_last);
    frame_end();

    // Random backpressure on the output.
    cur = tbl_b;
    send_frame(1'b0, t_last);
    collect(1'b1, N, t_last);
    frame_end();

    // Reset in the middle of DRAIN after 10 beats.
    cur = tbl_a;
    send_frame(1'b0, t_last);
    collect(1'b0, 10, t_last);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("mid_drain_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_reset", 32'(bus.energy_ready_o), 32'd1);
    exp_frame = '0;
    send_frame(1'b1, t_last);
    collect(1'b0, N, t_last);
    frame_end();

    // Frame counter wrap from 0xFFFF.
    force dut.frame_q = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.frame_q;
    @(negedge clk);
    chk("frame_preload", 32'(bus.frame_cnt_o), 32'h0000_FFFF);
    exp_frame = 16'hFFFF;
    cur = tbl_a;
    send_frame(1'b0, t_last);
    collect(1'b0, N, t_last);
    frame_end();
    chk("frame_wrapped", 32'(bus.frame_cnt_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
